// File: rtl/memory_stage_lsu_if.sv
// Execute-side, writeback-side and cache-bus signals of the memory stage LSU.
interface memory_stage_lsu_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_rd;
  logic [XLEN-1:0]   in_result;
  logic [XLEN-1:0]   in_store_data;
  logic              in_rd_w_v;
  logic              in_ld_v;
  logic              in_st_v;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic              out_valid;
  logic [REG_W-1:0]  out_rd;
  logic [XLEN-1:0]   out_result;
  logic              out_rd_w_v;
  logic              misalign_o;
  logic [XLEN-1:0]   bus_addr_o;
  logic              bus_read_o;
  logic              bus_write_o;
  logic [XLEN-1:0]   bus_wdata_o;
  logic [XLEN/8-1:0] bus_wmask_o;
  logic [XLEN-1:0]   bus_rdata_i;
  logic              bus_ack_i;

  modport slave (
    input  in_valid, in_rd, in_result, in_store_data, in_rd_w_v, in_ld_v, in_st_v,
           in_size, in_unsigned, bus_rdata_i, bus_ack_i,
    output in_ready, out_valid, out_rd, out_result, out_rd_w_v, misalign_o,
           bus_addr_o, bus_read_o, bus_write_o, bus_wdata_o, bus_wmask_o
  );
  modport master (
    output in_valid, in_rd, in_result, in_store_data, in_rd_w_v, in_ld_v, in_st_v,
           in_size, in_unsigned, bus_rdata_i, bus_ack_i,
    input  in_ready, out_valid, out_rd, out_result, out_rd_w_v, misalign_o,
           bus_addr_o, bus_read_o, bus_write_o, bus_wdata_o, bus_wmask_o
  );
endinterface

// File: rtl/memory_stage_lsu.sv
// Memory stage LSU: one outstanding sized load/store on the cache bus, pass-through otherwise.
// Optional bus wait timeout compiled in with MEMORY_TIMEOUT_EN.
module memory_stage_lsu #(
  parameter int XLEN           = 32,
  parameter int REG_W          = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  memory_stage_lsu_if.slave lsu
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic {IDLE, BUS} state_t;
  state_t state;

  logic [OW-1:0]    req_off;
  logic [1:0]       req_size;
  logic             req_unsigned, req_ld, req_rd_w_v;
  logic [REG_W-1:0] req_rd;
  logic [XLEN-1:0]  req_addr;

  assign lsu.in_ready = (state == IDLE);

  // Request decode from the execute-side inputs
  logic [OW-1:0]   offset, amask;
  logic            legal, is_mem;
  logic [15:0]     lanes;
  logic [NB-1:0]   wmask;
  logic [XLEN-1:0] wdata;

  always_comb begin
    offset = lsu.in_result[OW-1:0];
    amask  = OW'((4'd1 << lsu.in_size) - 4'd1);
    legal  = ({1'b0, lsu.in_size} <= 3'(OW)) && ((offset & amask) == '0);
    is_mem = lsu.in_ld_v || lsu.in_st_v;
    lanes  = 16'((17'd1 << (5'd1 << lsu.in_size)) - 17'd1);
    wmask  = NB'(lanes) << offset;
    wdata  = lsu.in_store_data << {offset, 3'b000};
  end

  // Load return alignment and extension
  logic [XLEN-1:0] shifted, lowmask, ld_data;
  logic [6:0]      nbits;
  logic            sbit;

  always_comb begin
    shifted = lsu.bus_rdata_i >> {req_off, 3'b000};
    nbits   = 7'd8 << req_size;
    lowmask = ({1'b0, req_size} >= 3'(OW)) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
    case (req_size)
      2'd0:    sbit = shifted[7];
      2'd1:    sbit = shifted[15];
      2'd2:    sbit = shifted[31];
      default: sbit = shifted[XLEN-1];
    endcase
    ld_data = (shifted & lowmask) | ((sbit && !req_unsigned) ? ~lowmask : '0);
  end

`ifdef MEMORY_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      lsu.out_valid    <= 1'b0;
      lsu.out_rd_w_v   <= 1'b0;
      lsu.misalign_o   <= 1'b0;
      lsu.bus_read_o   <= 1'b0;
      lsu.bus_write_o  <= 1'b0;
      lsu.out_rd       <= '0;
      lsu.out_result   <= '0;
      lsu.bus_addr_o   <= '0;
      lsu.bus_wdata_o  <= '0;
      lsu.bus_wmask_o  <= '0;
      req_off          <= '0;
      req_size         <= '0;
      req_unsigned     <= 1'b0;
      req_ld           <= 1'b0;
      req_rd_w_v       <= 1'b0;
      req_rd           <= '0;
      req_addr         <= '0;
`ifdef MEMORY_TIMEOUT_EN
      cnt              <= '0;
`endif
    end else begin
      lsu.out_valid  <= 1'b0;
      lsu.out_rd_w_v <= 1'b0;
      lsu.misalign_o <= 1'b0;
      case (state)
        IDLE: if (lsu.in_valid) begin
          if (!is_mem) begin
            lsu.out_valid  <= 1'b1;
            lsu.out_rd     <= lsu.in_rd;
            lsu.out_result <= lsu.in_result;
            lsu.out_rd_w_v <= lsu.in_rd_w_v;
          end else if (legal) begin
            state           <= BUS;
            lsu.bus_addr_o  <= lsu.in_result & ~XLEN'(NB - 1);
            lsu.bus_read_o  <= lsu.in_ld_v;
            lsu.bus_write_o <= lsu.in_st_v;
            lsu.bus_wmask_o <= wmask;
            lsu.bus_wdata_o <= wdata;
            req_off         <= offset;
            req_size        <= lsu.in_size;
            req_unsigned    <= lsu.in_unsigned;
            req_ld          <= lsu.in_ld_v;
            req_rd_w_v      <= lsu.in_rd_w_v;
            req_rd          <= lsu.in_rd;
            req_addr        <= lsu.in_result;
`ifdef MEMORY_TIMEOUT_EN
            cnt             <= '0;
`endif
          end else begin
            lsu.out_valid  <= 1'b1;
            lsu.out_rd     <= lsu.in_rd;
            lsu.out_result <= lsu.in_result;
            lsu.misalign_o <= 1'b1;
          end
        end
        BUS: if (lsu.bus_ack_i) begin
          state           <= IDLE;
          lsu.bus_read_o  <= 1'b0;
          lsu.bus_write_o <= 1'b0;
          lsu.out_valid   <= 1'b1;
          lsu.out_rd      <= req_rd;
          lsu.out_result  <= req_ld ? ld_data : req_addr;
          lsu.out_rd_w_v  <= req_ld && req_rd_w_v;
        end
`ifdef MEMORY_TIMEOUT_EN
        // Give up on a silent bus; reported through the shared fault pulse
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state           <= IDLE;
          lsu.bus_read_o  <= 1'b0;
          lsu.bus_write_o <= 1'b0;
          lsu.out_valid   <= 1'b1;
          lsu.out_rd      <= req_rd;
          lsu.out_result  <= req_addr;
          lsu.misalign_o  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
